// File: rtl/matmul_systolic_core_if.sv
// Operand/result bundle between the APB register block and the systolic core.
// master: register block side (drives operands and control, reads results).
// slave : core side.
interface matmul_systolic_core_if #(
   parameter int DW           = 8,
   parameter int BW           = 32,
   parameter int MAX_DIM      = BW / DW,
   parameter int Elements_Num = MAX_DIM * MAX_DIM
);
   logic [15:0]                control_reg_i;
   logic [BW*MAX_DIM-1:0]      operand_A_i;
   logic [BW*MAX_DIM-1:0]      operand_B_i;
   logic [BW*Elements_Num-1:0] operand_C_i;
   logic                       done_o;
   logic [BW*Elements_Num-1:0] result_o;
   logic [Elements_Num-1:0]    of_o;

   modport master (
      output control_reg_i, operand_A_i, operand_B_i, operand_C_i,
      input  done_o, result_o, of_o
   );

   modport slave (
      input  control_reg_i, operand_A_i, operand_B_i, operand_C_i,
      output done_o, result_o, of_o
   );
endinterface

// File: rtl/matmul_systolic_core.sv
// Output-stationary systolic matrix multiplier: Res = A x B + C.
// Signed DW-bit operands, BW-bit wrapping accumulators with sticky overflow.
// A flows rightward along rows, B flows downward along columns; PE(i,j)
// sees operand pair k at compute cycle t = i + j + k.
module matmul_systolic_core #(
   parameter int DW           = 8,
   parameter int BW           = 32,
   parameter int MAX_DIM      = BW / DW,
   parameter int Elements_Num = MAX_DIM * MAX_DIM
) (
   input logic                   clk_i,
   input logic                   reset_ni,
   matmul_systolic_core_if.slave bus
);

   localparam int CYCLES = 3 * MAX_DIM - 2;
   localparam int TW     = $clog2(CYCLES + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_LOAD,
      ST_COMPUTE,
      ST_DONE
   } state_t;

   state_t state_q, state_d;
   logic   load_en, compute_en;
   logic   start;

   logic [TW-1:0] t_q;
   int unsigned   tt;

   // dimension fields hold (size - 1)
   logic [1:0] m_q, k_q, n_q;

   logic signed [DW-1:0]   a_q    [MAX_DIM][MAX_DIM];
   logic signed [DW-1:0]   b_q    [MAX_DIM][MAX_DIM];
   logic signed [DW-1:0]   a_pipe [MAX_DIM][MAX_DIM-1];
   logic signed [DW-1:0]   b_pipe [MAX_DIM-1][MAX_DIM];
   logic signed [DW-1:0]   a_in   [MAX_DIM][MAX_DIM];
   logic signed [DW-1:0]   b_in   [MAX_DIM][MAX_DIM];
   logic signed [2*DW-1:0] prod   [MAX_DIM][MAX_DIM];
   logic signed [BW-1:0]   prod_x [MAX_DIM][MAX_DIM];
   logic [BW-1:0]          acc_q  [MAX_DIM][MAX_DIM];
   logic [BW-1:0]          sum_d  [MAX_DIM][MAX_DIM];
   logic                   ovf    [MAX_DIM][MAX_DIM];
   logic [Elements_Num-1:0] of_q;

   assign start = bus.control_reg_i[0];

   // FSM state register
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) state_q <= ST_IDLE;
      else           state_q <= state_d;
   end

   // FSM next-state and phase strobes
   always_comb begin
      state_d    = state_q;
      load_en    = 1'b0;
      compute_en = 1'b0;
      unique case (state_q)
         ST_IDLE:    if (start) state_d = ST_SETTLE;
         ST_SETTLE:  state_d = ST_LOAD;
         ST_LOAD: begin
            load_en = 1'b1;
            state_d = ST_COMPUTE;
         end
         ST_COMPUTE: begin
            compute_en = 1'b1;
            if (t_q == TW'(CYCLES - 1)) state_d = ST_DONE;
         end
         ST_DONE:    if (!start) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Edge injection with skew and dimension masking, then PE operand routing
   always_comb begin
      tt = 32'(t_q);
      for (int unsigned i = 0; i < MAX_DIM; i++) begin
         for (int unsigned j = 0; j < MAX_DIM; j++) begin
            a_in[i][j] = '0;
            b_in[i][j] = '0;
         end
      end
      for (int unsigned i = 0; i < MAX_DIM; i++) begin
         for (int unsigned k = 0; k < MAX_DIM; k++) begin
            if (32'(k_q) >= k && 32'(m_q) >= i && tt == i + k) a_in[i][0] = a_q[i][k];
         end
         for (int unsigned j = 1; j < MAX_DIM; j++) a_in[i][j] = a_pipe[i][j-1];
      end
      for (int unsigned j = 0; j < MAX_DIM; j++) begin
         for (int unsigned k = 0; k < MAX_DIM; k++) begin
            if (32'(k_q) >= k && 32'(n_q) >= j && tt == j + k) b_in[0][j] = b_q[k][j];
         end
         for (int unsigned i = 1; i < MAX_DIM; i++) b_in[i][j] = b_pipe[i-1][j];
      end
   end

   // PE multiply-accumulate with signed overflow detection
   always_comb begin
      for (int unsigned i = 0; i < MAX_DIM; i++) begin
         for (int unsigned j = 0; j < MAX_DIM; j++) begin
            prod[i][j]   = a_in[i][j] * b_in[i][j];
            prod_x[i][j] = prod[i][j];
            sum_d[i][j]  = acc_q[i][j] + prod_x[i][j];
            ovf[i][j]    = (acc_q[i][j][BW-1] == prod_x[i][j][BW-1]) &&
                           (sum_d[i][j][BW-1] != acc_q[i][j][BW-1]);
         end
      end
   end

   // Operand capture, accumulator load/update, skew pipelines and cycle counter
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         t_q    <= '0;
         m_q    <= '0;
         k_q    <= '0;
         n_q    <= '0;
         a_q    <= '{default: '0};
         b_q    <= '{default: '0};
         a_pipe <= '{default: '0};
         b_pipe <= '{default: '0};
         acc_q  <= '{default: '0};
         of_q   <= '0;
      end else if (load_en) begin
         t_q    <= '0;
         m_q    <= bus.control_reg_i[9:8];
         k_q    <= bus.control_reg_i[11:10];
         n_q    <= bus.control_reg_i[13:12];
         a_pipe <= '{default: '0};
         b_pipe <= '{default: '0};
         of_q   <= '0;
         for (int unsigned i = 0; i < MAX_DIM; i++) begin
            for (int unsigned k = 0; k < MAX_DIM; k++) begin
               a_q[i][k] <= bus.operand_A_i[BW*i + DW*k +: DW];
               b_q[i][k] <= bus.operand_B_i[BW*i + DW*k +: DW];
            end
         end
         // bias outside the active M x N window is dropped so stale C data cannot leak
         for (int unsigned i = 0; i < MAX_DIM; i++) begin
            for (int unsigned j = 0; j < MAX_DIM; j++) begin
               if (32'(bus.control_reg_i[9:8]) >= i && 32'(bus.control_reg_i[13:12]) >= j)
                  acc_q[i][j] <= bus.operand_C_i[BW*(i*MAX_DIM + j) +: BW];
               else
                  acc_q[i][j] <= '0;
            end
         end
      end else if (compute_en) begin
         t_q <= t_q + 1'b1;
         for (int unsigned i = 0; i < MAX_DIM; i++) begin
            for (int unsigned j = 0; j < MAX_DIM; j++) begin
               acc_q[i][j] <= sum_d[i][j];
               if (ovf[i][j]) of_q[i*MAX_DIM + j] <= 1'b1;
            end
         end
         for (int unsigned i = 0; i < MAX_DIM; i++) begin
            for (int unsigned j = 0; j < MAX_DIM - 1; j++) a_pipe[i][j] <= a_in[i][j];
         end
         for (int unsigned i = 0; i < MAX_DIM - 1; i++) begin
            for (int unsigned j = 0; j < MAX_DIM; j++) b_pipe[i][j] <= b_in[i][j];
         end
      end
   end

   // Flatten accumulators onto the result bus
   always_comb begin
      bus.result_o = '0;
      for (int unsigned i = 0; i < MAX_DIM; i++) begin
         for (int unsigned j = 0; j < MAX_DIM; j++) begin
            bus.result_o[BW*(i*MAX_DIM + j) +: BW] = acc_q[i][j];
         end
      end
   end

   assign bus.of_o   = of_q;
   assign bus.done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_matmul_systolic_core.sv
// Scoreboard bench for matmul_systolic_core: directed operand sets with
// hand-computed results; a negedge monitor compares on each done_o rise.
module tb_matmul_systolic_core;
   localparam int DW = 8;
   localparam int BW = 32;
   localparam int MD = 4;
   localparam int EN = 16;
   localparam int RW = BW * EN;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   matmul_systolic_core_if #(.DW(DW), .BW(BW)) bus_if ();

   matmul_systolic_core #(.DW(DW), .BW(BW)) dut (
      .clk_i    (clk),
      .reset_ni (reset_n),
      .bus      (bus_if)
   );

   typedef struct {
      string         name;
      logic [RW-1:0] res;
      logic [EN-1:0] of;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks  = 0;
   int   n_pass    = 0;
   logic done_prev = 1'b0;

   logic [BW*MD-1:0] a_v, b_v;
   logic [RW-1:0]    c_v, exp_res;
   logic [EN-1:0]    exp_of;

   task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", nm, act, req);
   endtask

   task automatic set_a(input int i, input int k, input logic [7:0] v);
      a_v[BW*i + DW*k +: DW] = v;
   endtask

   task automatic set_b(input int k, input int j, input logic [7:0] v);
      b_v[BW*k + DW*j +: DW] = v;
   endtask

   task automatic set_c(input int i, input int j, input logic [31:0] v);
      c_v[BW*(i*MD + j) +: BW] = v;
   endtask

   task automatic set_r(input int i, input int j, input logic [31:0] v);
      exp_res[BW*(i*MD + j) +: BW] = v;
   endtask

   // bits 15 and 4 are don't-care garbage the core must ignore
   function automatic logic [15:0] ctl(input int m, input int k, input int n, input logic st);
      logic [1:0] mf, kf, nf;
      mf = 2'(m - 1);
      kf = 2'(k - 1);
      nf = 2'(n - 1);
      return 16'h8010 | {2'b00, nf, kf, mf, 7'b0, st};
   endfunction

   task automatic run_op(input string nm, input int m, input int k, input int n, input int hold);
      int lat;
      @(negedge clk);
      bus_if.operand_A_i   = a_v;
      bus_if.operand_B_i   = b_v;
      bus_if.operand_C_i   = c_v;
      bus_if.control_reg_i = ctl(m, k, n, 1'b1);
      sb_q.push_back('{nm, exp_res, exp_of});
      lat = -1;
      for (int e = 0; e < 40; e++) begin
         @(posedge clk);
         #1;
         if (bus_if.done_o === 1'b1) begin
            lat = e;
            break;
         end
      end
      chk({nm, " latency"}, lat, 12);
      for (int c = 0; c < hold; c++) begin
         @(posedge clk);
         #1;
         chk({nm, " done_held"}, RW'(bus_if.done_o), 1);
         chk({nm, " result_stable"}, bus_if.result_o, exp_res);
      end
      @(negedge clk);
      bus_if.control_reg_i = ctl(m, k, n, 1'b0);
      @(posedge clk);
      #1;
      chk({nm, " done_drop"}, RW'(bus_if.done_o), 0);
      chk({nm, " result_idle"}, bus_if.result_o, exp_res);
      chk({nm, " of_idle"}, RW'(bus_if.of_o), RW'(exp_of));
   endtask

   // Monitor: pop and compare on every rising done_o
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus_if.done_o === 1'b1 && done_prev !== 1'b1) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_done: got done_o with empty queue, required no done_o");
            end else begin
               e = sb_q.pop_front();
               chk({e.name, " result"}, bus_if.result_o, e.res);
               chk({e.name, " of"}, RW'(bus_if.of_o), RW'(e.of));
            end
         end
         done_prev = bus_if.done_o;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion, required finish before time limit");
      $fatal(1);
   end

   initial begin
      bus_if.control_reg_i = '0;
      bus_if.operand_A_i   = '0;
      bus_if.operand_B_i   = '0;
      bus_if.operand_C_i   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset done", RW'(bus_if.done_o), 0);
      chk("reset result", bus_if.result_o, 0);
      chk("reset of", RW'(bus_if.of_o), 0);
      @(negedge clk);
      reset_n = 1'b1;

      // identity: A = I, B[k][j] = 4k + j, result equals B
      a_v = '0; b_v = '0; c_v = '0; exp_res = '0; exp_of = '0;
      for (int i = 0; i < MD; i++) set_a(i, i, 8'd1);
      for (int k = 0; k < MD; k++)
         for (int j = 0; j < MD; j++) begin
            set_b(k, j, 8'(k*4 + j));
            set_r(k, j, 32'(k*4 + j));
         end
      run_op("identity", 4, 4, 4, 17);

      // signed extremes: 4 * (-128 * 127) = -65024
      for (int i = 0; i < MD; i++)
         for (int j = 0; j < MD; j++) begin
            set_a(i, j, 8'h80);
            set_b(i, j, 8'h7F);
            set_r(i, j, 32'hFFFF_0200);
         end
      c_v = '0; exp_of = '0;
      run_op("signed", 4, 4, 4, 20);

      // reduced M=2 K=3 N=1 with garbage everywhere outside the window
      a_v = {16{8'h5A}}; b_v = {16{8'hC3}}; c_v = {16{32'h1234_5678}};
      exp_res = '0; exp_of = '0;
      set_a(0, 0, 8'd1);  set_a(0, 1, 8'd2);  set_a(0, 2, 8'd3);
      set_a(1, 0, 8'hFF); set_a(1, 1, 8'd4);  set_a(1, 2, 8'hFE);
      set_b(0, 0, 8'd5);  set_b(1, 0, 8'hFD); set_b(2, 0, 8'd7);
      set_c(0, 0, 32'd100);
      set_c(1, 0, 32'd0);
      set_r(0, 0, 32'd120);
      set_r(1, 0, 32'hFFFF_FFE1);
      run_op("reduced", 2, 3, 1, 17);

      // bias overflow on element 0 only
      a_v = '0; b_v = '0; c_v = '0; exp_res = '0;
      set_a(0, 0, 8'd1); set_b(0, 0, 8'd1);
      set_c(0, 0, 32'h7FFF_FFFF);
      set_r(0, 0, 32'h8000_0000);
      exp_of = 16'h0001;
      run_op("bias_ovf", 4, 4, 4, 17);

      // reset during COMPUTE at t=5
      for (int i = 0; i < MD; i++)
         for (int j = 0; j < MD; j++) begin
            set_a(i, j, 8'h80);
            set_b(i, j, 8'h7F);
         end
      c_v = '0;
      @(negedge clk);
      bus_if.operand_A_i   = a_v;
      bus_if.operand_B_i   = b_v;
      bus_if.operand_C_i   = c_v;
      bus_if.control_reg_i = ctl(4, 4, 4, 1'b1);
      repeat (8) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midreset done", RW'(bus_if.done_o), 0);
      chk("midreset result", bus_if.result_o, 0);
      chk("midreset of", RW'(bus_if.of_o), 0);
      bus_if.control_reg_i = ctl(4, 4, 4, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;

      // full operation after reset
      a_v = '0; b_v = '0; c_v = '0; exp_res = '0; exp_of = '0;
      for (int i = 0; i < MD; i++) set_a(i, i, 8'd1);
      for (int k = 0; k < MD; k++)
         for (int j = 0; j < MD; j++) begin
            set_b(k, j, 8'(k*4 + j));
            set_r(k, j, 32'(k*4 + j));
         end
      run_op("after_reset", 4, 4, 4, 17);

      repeat (2) @(posedge clk);
      chk("scoreboard_empty", RW'(sb_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
